// File: rtl/overture_io_port.sv
// Host-side I/O port for the Overture CPU: a host-to-CPU byte FIFO and a
// CPU-to-host byte FIFO, each with a sticky error flag for illegal accesses.
module overture_io_port #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    host_in_data,
    input  logic          host_in_valid,
    output logic          host_in_ready,
    output logic [7:0]    cpu_input,
    input  logic          cpu_in_rd,
    input  logic [7:0]    cpu_output,
    input  logic          cpu_out_wr,
    output logic [7:0]    host_out_data,
    output logic          host_out_valid,
    input  logic          host_out_ready,
    output logic [CW-1:0] in_count,
    output logic [CW-1:0] out_count,
    output logic          underrun,
    output logic          overrun,
    input  logic          err_clr
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                                 input logic          push,
                                                 input logic          pop);
        logic [CW-1:0] res;
        res = cnt;
        case ({push, pop})
            2'b10:   res = cnt + CW'(1);
            2'b01:   res = cnt - CW'(1);
            default: res = cnt;
        endcase
        return res;
    endfunction

    logic [7:0]    r_in_mem  [DEPTH];
    logic [AW-1:0] r_in_wptr;
    logic [AW-1:0] r_in_rptr;
    logic [CW-1:0] r_in_count;

    logic [7:0]    r_out_mem [DEPTH];
    logic [AW-1:0] r_out_wptr;
    logic [AW-1:0] r_out_rptr;
    logic [CW-1:0] r_out_count;

    logic          r_underrun;
    logic          r_overrun;

    logic w_in_full;
    logic w_in_empty;
    logic w_in_push;
    logic w_in_pop;
    logic w_underrun_ev;
    logic w_out_full;
    logic w_out_empty;
    logic w_out_push;
    logic w_out_pop;
    logic w_overrun_ev;

    // Full/empty come from the registered counts, so a pop cannot free a slot
    // for a push in the same cycle.
    assign w_in_full     = (r_in_count == FULL_CNT);
    assign w_in_empty    = (r_in_count == '0);
    assign w_in_push     = host_in_valid && !w_in_full;
    assign w_in_pop      = cpu_in_rd && !w_in_empty;
    assign w_underrun_ev = cpu_in_rd && w_in_empty;

    assign w_out_full    = (r_out_count == FULL_CNT);
    assign w_out_empty   = (r_out_count == '0);
    assign w_out_push    = cpu_out_wr && !w_out_full;
    assign w_out_pop     = host_out_ready && !w_out_empty;
    assign w_overrun_ev  = cpu_out_wr && w_out_full;

    // Storage holds data only; it is never reset.
    always_ff @(posedge clk) begin
        if (w_in_push) begin
            r_in_mem[r_in_wptr] <= host_in_data;
        end
        if (w_out_push) begin
            r_out_mem[r_out_wptr] <= cpu_output;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_in_wptr   <= '0;
            r_in_rptr   <= '0;
            r_in_count  <= '0;
            r_out_wptr  <= '0;
            r_out_rptr  <= '0;
            r_out_count <= '0;
            r_underrun  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_in_push) begin
                r_in_wptr <= r_in_wptr + AW'(1);
            end
            if (w_in_pop) begin
                r_in_rptr <= r_in_rptr + AW'(1);
            end
            r_in_count <= next_count(r_in_count, w_in_push, w_in_pop);

            if (w_out_push) begin
                r_out_wptr <= r_out_wptr + AW'(1);
            end
            if (w_out_pop) begin
                r_out_rptr <= r_out_rptr + AW'(1);
            end
            r_out_count <= next_count(r_out_count, w_out_push, w_out_pop);

            // A new error in the same cycle as err_clr leaves the flag set.
            r_underrun <= (r_underrun && !err_clr) || w_underrun_ev;
            r_overrun  <= (r_overrun  && !err_clr) || w_overrun_ev;
        end
    end

    assign host_in_ready  = !w_in_full;
    assign cpu_input      = w_in_empty ? 8'h00 : r_in_mem[r_in_rptr];
    assign host_out_valid = !w_out_empty;
    assign host_out_data  = w_out_empty ? 8'h00 : r_out_mem[r_out_rptr];
    assign in_count       = r_in_count;
    assign out_count      = r_out_count;
    assign underrun       = r_underrun;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_overture_io_port.sv
// Testbench for overture_io_port: directed scenarios plus randomized traffic
// checked against a queue-based model of both FIFOs and the sticky flags.
module tb_overture_io_port;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    host_in_data = 8'h00;
    logic          host_in_valid = 1'b0;
    logic          host_in_ready;
    logic [7:0]    cpu_input;
    logic          cpu_in_rd = 1'b0;
    logic [7:0]    cpu_output = 8'h00;
    logic          cpu_out_wr = 1'b0;
    logic [7:0]    host_out_data;
    logic          host_out_valid;
    logic          host_out_ready = 1'b0;
    logic [CW-1:0] in_count;
    logic [CW-1:0] out_count;
    logic          underrun;
    logic          overrun;
    logic          err_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_in_q[$];
    logic [7:0] m_out_q[$];
    logic       m_underrun = 1'b0;
    logic       m_overrun  = 1'b0;

    overture_io_port #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .cpu_input      (cpu_input),
        .cpu_in_rd      (cpu_in_rd),
        .cpu_output     (cpu_output),
        .cpu_out_wr     (cpu_out_wr),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .in_count       (in_count),
        .out_count      (out_count),
        .underrun       (underrun),
        .overrun        (overrun),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_in_head();
        return (m_in_q.size() != 0) ? m_in_q[0] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_out_head();
        return (m_out_q.size() != 0) ? m_out_q[0] : 8'h00;
    endfunction

    // One clock edge; the model advances from the inputs seen at that edge.
    task automatic tick();
        bit in_full, in_empty, out_full, out_empty;
        @(posedge clk);
        if (!rst) begin
            m_in_q.delete();
            m_out_q.delete();
            m_underrun = 1'b0;
            m_overrun  = 1'b0;
        end else begin
            in_full   = (m_in_q.size() == DEPTH);
            in_empty  = (m_in_q.size() == 0);
            out_full  = (m_out_q.size() == DEPTH);
            out_empty = (m_out_q.size() == 0);
            if (err_clr) begin
                m_underrun = 1'b0;
                m_overrun  = 1'b0;
            end
            if (cpu_in_rd && in_empty) m_underrun = 1'b1;
            if (cpu_out_wr && out_full) m_overrun = 1'b1;
            if (cpu_in_rd && !in_empty) void'(m_in_q.pop_front());
            if (host_in_valid && !in_full) m_in_q.push_back(host_in_data);
            if (host_out_ready && !out_empty) void'(m_out_q.pop_front());
            if (cpu_out_wr && !out_full) m_out_q.push_back(cpu_output);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        host_in_valid  = 1'b0;
        cpu_in_rd      = 1'b0;
        cpu_out_wr     = 1'b0;
        host_out_ready = 1'b0;
        err_clr        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        host_in_valid = 1'b1;
        host_in_data  = 8'hAA;
        cpu_out_wr    = 1'b1;
        cpu_output    = 8'hBB;
        tick();
        tick();
        rst = 1'b1;
        idle_inputs();
        checks++; if (in_count !== '0) begin errors++; $display("FAIL reset_in_count: got %0d want 0", in_count); end
        checks++; if (out_count !== '0) begin errors++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
        checks++; if (host_in_ready !== 1'b1) begin errors++; $display("FAIL reset_host_in_ready: got %b want 1", host_in_ready); end
        checks++; if (host_out_valid !== 1'b0) begin errors++; $display("FAIL reset_host_out_valid: got %b want 0", host_out_valid); end
        checks++; if (underrun !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b want 00", underrun, overrun); end
        checks++; if (cpu_input !== 8'h00) begin errors++; $display("FAIL reset_cpu_input: got %h want 00", cpu_input); end
        checks++; if (host_out_data !== 8'h00) begin errors++; $display("FAIL reset_host_out_data: got %h want 00", host_out_data); end
    endtask

    task automatic test_in_order_wrap();
        logic [7:0] pat [4];
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                host_in_valid = 1'b1;
                host_in_data  = pat[i];
                tick();
            end
            host_in_valid = 1'b0;
            checks++; if (in_count !== CW'(4)) begin errors++; $display("FAIL order_full_count r%0d: got %0d want 4", r, in_count); end
            checks++; if (host_in_ready !== 1'b0) begin errors++; $display("FAIL order_full_ready r%0d: got %b want 0", r, host_in_ready); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (cpu_input !== pat[i]) begin errors++; $display("FAIL order_data r%0d i%0d: got %h want %h", r, i, cpu_input, pat[i]); end
                cpu_in_rd = 1'b1;
                tick();
                cpu_in_rd = 1'b0;
            end
            checks++; if (cpu_input !== 8'h00 || in_count !== '0) begin errors++; $display("FAIL order_drained r%0d: got %h/%0d want 00/0", r, cpu_input, in_count); end
        end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL order_no_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            host_in_valid = 1'b1;
            host_in_data  = b[i];
            tick();
        end
        host_in_data = 8'h55;
        cpu_in_rd    = 1'b1;
        tick();
        idle_inputs();
        checks++; if (in_count !== CW'(3)) begin errors++; $display("FAIL fullpp_count: got %0d want 3", in_count); end
        checks++; if (host_in_ready !== 1'b1) begin errors++; $display("FAIL fullpp_ready: got %b want 1", host_in_ready); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (cpu_input !== b[i]) begin errors++; $display("FAIL fullpp_data i%0d: got %h want %h", i, cpu_input, b[i]); end
            cpu_in_rd = 1'b1;
            tick();
            cpu_in_rd = 1'b0;
        end
        checks++; if (cpu_input !== 8'h00 || in_count !== '0) begin errors++; $display("FAIL fullpp_55_dropped: got %h/%0d want 00/0", cpu_input, in_count); end
    endtask

    task automatic test_underrun();
        cpu_in_rd = 1'b1;
        tick();
        cpu_in_rd = 1'b0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL urun_set: got %b want 1", underrun); end
        checks++; if (cpu_input !== 8'h00 || in_count !== '0) begin errors++; $display("FAIL urun_empty: got %h/%0d want 00/0", cpu_input, in_count); end
        err_clr = 1'b1; cpu_in_rd = 1'b1;
        tick();
        err_clr = 1'b0; cpu_in_rd = 1'b0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL urun_set_wins: got %b want 1", underrun); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL urun_clear: got %b want 0", underrun); end
        host_in_valid = 1'b1; host_in_data = 8'hC3; cpu_in_rd = 1'b1;
        tick();
        host_in_valid = 1'b0; cpu_in_rd = 1'b0;
        checks++; if (in_count !== CW'(1) || cpu_input !== 8'hC3) begin errors++; $display("FAIL urun_empty_pushpop: got %0d/%h want 1/c3", in_count, cpu_input); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL urun_empty_pushpop_flag: got %b want 1", underrun); end
        err_clr = 1'b1; cpu_in_rd = 1'b1;
        tick();
        err_clr = 1'b0; cpu_in_rd = 1'b0;
        checks++; if (underrun !== 1'b0 || in_count !== '0) begin errors++; $display("FAIL urun_pop_clear: got %b/%0d want 0/0", underrun, in_count); end
    endtask

    task automatic test_out_overrun();
        host_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpu_out_wr = 1'b1;
            cpu_output = 8'hA0 + 8'(i);
            tick();
        end
        cpu_out_wr = 1'b0;
        checks++; if (out_count !== CW'(4)) begin errors++; $display("FAIL orun_count: got %0d want 4", out_count); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL orun_flag: got %b want 1", overrun); end
        checks++; if (host_out_valid !== 1'b1) begin errors++; $display("FAIL orun_valid: got %b want 1", host_out_valid); end
        host_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (host_out_data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL orun_data i%0d: got %h want %h", i, host_out_data, 8'hA0 + 8'(i)); end
            tick();
        end
        host_out_ready = 1'b0;
        checks++; if (host_out_valid !== 1'b0 || host_out_data !== 8'h00) begin errors++; $display("FAIL orun_a4_lost: got %b/%h want 0/00", host_out_valid, host_out_data); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL orun_clear: got %b want 0", overrun); end
    endtask

    task automatic test_streaming();
        logic [7:0] prev;
        host_in_valid  = 1'b1;
        host_in_data   = 8'h00;
        host_out_ready = 1'b1;
        tick();
        cpu_in_rd = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            checks++; if (cpu_input !== 8'(n - 1) || in_count > CW'(1)) begin errors++; $display("FAIL stream_in n%0d: got %h/%0d want %h/<=1", n, cpu_input, in_count, 8'(n - 1)); end
            host_in_data = 8'(n);
            cpu_out_wr   = 1'b1;
            cpu_output   = ~8'(n);
            prev         = cpu_output;
            tick();
            checks++; if (host_out_data !== prev || out_count > CW'(1)) begin errors++; $display("FAIL stream_out n%0d: got %h/%0d want %h/<=1", n, host_out_data, out_count, prev); end
            checks++; if (underrun !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL stream_flags n%0d: got %b%b want 00", n, underrun, overrun); end
        end
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (in_count !== '0 || out_count !== '0) begin errors++; $display("FAIL midreset_discard: got %0d/%0d want 0/0", in_count, out_count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst            = ($urandom_range(0, 99) != 0);
            host_in_valid  = ($urandom_range(0, 2) != 0);
            host_in_data   = 8'($urandom);
            cpu_in_rd      = ($urandom_range(0, 2) == 0);
            cpu_out_wr     = ($urandom_range(0, 1) == 0);
            cpu_output     = 8'($urandom);
            host_out_ready = ($urandom_range(0, 2) == 0);
            err_clr        = ($urandom_range(0, 15) == 0);
            tick();
            checks++; if (in_count !== CW'(m_in_q.size()) || host_in_ready !== (m_in_q.size() != DEPTH)) begin errors++; $display("FAIL rand_in_count c%0d: got %0d/%b want %0d", c, in_count, host_in_ready, m_in_q.size()); end
            checks++; if (cpu_input !== exp_in_head()) begin errors++; $display("FAIL rand_cpu_input c%0d: got %h want %h", c, cpu_input, exp_in_head()); end
            checks++; if (out_count !== CW'(m_out_q.size()) || host_out_valid !== (m_out_q.size() != 0)) begin errors++; $display("FAIL rand_out_count c%0d: got %0d/%b want %0d", c, out_count, host_out_valid, m_out_q.size()); end
            checks++; if (host_out_data !== exp_out_head()) begin errors++; $display("FAIL rand_host_out_data c%0d: got %h want %h", c, host_out_data, exp_out_head()); end
            checks++; if (underrun !== m_underrun || overrun !== m_overrun) begin errors++; $display("FAIL rand_flags c%0d: got %b%b want %b%b", c, underrun, overrun, m_underrun, m_overrun); end
        end
        idle_inputs();
        rst = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_in_order_wrap();
        test_full_push_pop();
        test_underrun();
        test_out_overrun();
        test_streaming();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
